// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run/pause/lap/clear controller for a BCD min:sec:10ms counter clocked at
// 100 Hz. Two raw push-buttons are synchronised, debounced and reduced to
// single-cycle press events, which drive a four-state FSM.
//
// Ports:
//   clk        system clock (same clock as the counter core)
//   rst        asynchronous, active-high reset
//   btn_ss_i   raw start/stop button, active-high, asynchronous
//   btn_lr_i   raw lap/reset button, active-high, asynchronous
//   min_i      live BCD minutes from the counter core
//   sec_i      live BCD seconds from the counter core
//   ms_10_i    live BCD hundredths from the counter core
//   cnt_en_o   count enable to the counter core (registered)
//   cnt_clr_o  one-cycle synchronous clear to the counter core (registered)
//   min_o      displayed minutes (lap value in LAP, live value otherwise)
//   sec_o      displayed seconds
//   ms_10_o    displayed hundredths
//   state_o    FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3
//
// Handshake note: there is no valid/ready handshake here. Press events are
// single-cycle strobes consumed by the FSM in the cycle they are high; the
// counter interface is level (cnt_en_o) plus a one-cycle strobe (cnt_clr_o).
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss_i,
  input  logic       btn_lr_i,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  output logic       cnt_en_o,
  output logic       cnt_clr_o,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Counter value at which the debounced level flips: the synchronised
  // level must have differed on DB_CYCLES consecutive edges.
  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  // Index 0 = start/stop, index 1 = lap/reset.
  logic [1:0] raw;
  logic [1:0] sync_1;
  logic [1:0] sync_2;
  logic [1:0] db_lvl;
  logic [1:0] db_lvl_d;
  logic [3:0] db_cnt [2];
  logic [1:0] press;

  assign raw = {btn_lr_i, btn_ss_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= '0;
      sync_2    <= '0;
      db_lvl    <= '0;
      db_lvl_d  <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_1   <= raw;
      sync_2   <= sync_1;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_lvl[i] <= sync_2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 4'd1;
          end
        end else begin
          // Any return to the debounced level restarts the count.
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edge of the debounced level only; release produces nothing.
  assign press = db_lvl & ~db_lvl_d;

  logic       ss_press;
  logic       lr_press;
  state_t     state;
  logic [7:0] lap_min;
  logic [7:0] lap_sec;
  logic [7:0] lap_ms_10;

  assign ss_press = press[0];
  // Start/stop wins a same-cycle tie; the lap/reset press is dropped.
  assign lr_press = press[1] & ~press[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt_en_o  <= 1'b0;
      cnt_clr_o <= 1'b0;
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_ms_10 <= '0;
    end else begin
      cnt_clr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_press) begin
            state    <= RUN;
            cnt_en_o <= 1'b1;
          end else if (lr_press) begin
            cnt_clr_o <= 1'b1;
          end
        end
        RUN: begin
          if (ss_press) begin
            state    <= PAUSE;
            cnt_en_o <= 1'b0;
          end else if (lr_press) begin
            state     <= LAP;
            lap_min   <= min_i;
            lap_sec   <= sec_i;
            lap_ms_10 <= ms_10_i;
          end
        end
        LAP: begin
          if (ss_press) begin
            state    <= PAUSE;
            cnt_en_o <= 1'b0;
          end else if (lr_press) begin
            state <= RUN;
          end
        end
        PAUSE: begin
          if (ss_press) begin
            state    <= RUN;
            cnt_en_o <= 1'b1;
          end else if (lr_press) begin
            state     <= IDLE;
            cnt_clr_o <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt_en_o <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

  // Display mux: frozen lap value only while in LAP, live count otherwise.
  assign min_o   = (state == LAP) ? lap_min   : min_i;
  assign sec_o   = (state == LAP) ? lap_sec   : sec_i;
  assign ms_10_o = (state == LAP) ? lap_ms_10 : ms_10_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  // clock / reset
  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic [7:0] min_in;
  logic [7:0] sec_in;
  logic [7:0] ms_in;
  logic       cnt_en;
  logic       cnt_clr;
  logic [7:0] min_out;
  logic [7:0] sec_out;
  logic [7:0] ms_out;
  logic [1:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(.DB_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss_i  (btn_ss),
    .btn_lr_i  (btn_lr),
    .min_i     (min_in),
    .sec_i     (sec_in),
    .ms_10_i   (ms_in),
    .cnt_en_o  (cnt_en),
    .cnt_clr_o (cnt_clr),
    .min_o     (min_out),
    .sec_o     (sec_out),
    .ms_10_o   (ms_out),
    .state_o   (state)
  );

  // scoreboard: {cycle[15:0], state, en, clr, min, sec, ms}
  logic [43:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [27:0] v(input logic [1:0] st, input logic en,
                                    input logic clr, input logic [7:0] mi,
                                    input logic [7:0] se, input logic [7:0] ms);
    return {st, en, clr, mi, se, ms};
  endfunction

  task automatic push(input int c, input string nm, input logic [27:0] val);
    exp_q.push_back({c[15:0], val});
    name_q.push_back(nm);
  endtask

  // monitor: samples on the falling edge, away from the active edge
  logic [43:0] mon_e;
  logic [27:0] mon_got;
  string       mon_n;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][43:28] <= cyc[15:0]) begin
      mon_e   = exp_q.pop_front();
      mon_n   = name_q.pop_front();
      mon_got = {state, cnt_en, cnt_clr, min_out, sec_out, ms_out};
      checks++;
      if (mon_e[43:28] != cyc[15:0]) begin
        errors++;
        $display("FAIL %s: sample for cycle %0d missed (now %0d)", mon_n, mon_e[43:28], cyc);
      end else if (mon_got !== mon_e[27:0]) begin
        errors++;
        $display("FAIL %s @cycle %0d: got st=%0d en=%b clr=%b disp=%h:%h:%h, expected st=%0d en=%b clr=%b disp=%h:%h:%h",
                 mon_n, cyc, mon_got[27:26], mon_got[25], mon_got[24], mon_got[23:16],
                 mon_got[15:8], mon_got[7:0], mon_e[27:26], mon_e[25], mon_e[24],
                 mon_e[23:16], mon_e[15:8], mon_e[7:0]);
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the falling edge
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_live(input logic [7:0] mi, input logic [7:0] se, input logic [7:0] ms);
    min_in = mi;
    sec_in = se;
    ms_in  = ms;
  endtask

  // Button(s) go high; first sampled at edge c+1, so the FSM moves at c+6.
  task automatic press(input logic s, input logic l, input string nm,
                       input logic [27:0] pre, input logic [27:0] at,
                       input logic [27:0] post,
                       input logic [7:0] nmi, input logic [7:0] nse, input logic [7:0] nms);
    int c;
    c = cyc;
    btn_ss = s;
    btn_lr = l;
    for (int k = 1; k <= 5; k++) push(c + k, {nm, "_pre"}, pre);
    push(c + 6, {nm, "_edge"}, at);
    tick(6);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    set_live(nmi, nse, nms);
    c = cyc;
    for (int k = 1; k <= 10; k++) push(c + k, {nm, "_after"}, post);
    tick(10);
  endtask

  initial begin
    int c;
    rst    = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    set_live(8'h00, 8'h00, 8'h00);

    tick(1);
    c = cyc;
    push(c + 1, "in_reset", v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    tick(2);
    rst = 1'b0;
    c = cyc;
    push(c + 1, "reset_idle", v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    push(c + 2, "reset_idle", v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    tick(2);

    // short pulse seen on 2 edges: no event
    c = cyc;
    btn_ss = 1'b1;
    tick(2);
    btn_ss = 1'b0;
    for (int k = 1; k <= 12; k++) push(c + 2 + k, "short_ss", v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    tick(12);

    // start/stop held 20 cycles: one transition at E+5
    c = cyc;
    btn_ss = 1'b1;
    for (int k = 1; k <= 5; k++) push(c + k, "ss_latency", v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    for (int k = 6; k <= 20; k++) push(c + k, "ss_held", v(S_RUN, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00));
    tick(20);
    btn_ss = 1'b0;
    set_live(8'h01, 8'h23, 8'h45);
    c = cyc;
    for (int k = 1; k <= 10; k++) push(c + k, "ss_release", v(S_RUN, 1'b1, 1'b0, 8'h01, 8'h23, 8'h45));
    tick(10);

    // lap capture, then inputs advance while the display holds
    press(1'b0, 1'b1, "lap_in",
          v(S_RUN, 1'b1, 1'b0, 8'h01, 8'h23, 8'h45),
          v(S_LAP, 1'b1, 1'b0, 8'h01, 8'h23, 8'h45),
          v(S_LAP, 1'b1, 1'b0, 8'h01, 8'h23, 8'h45),
          8'h01, 8'h24, 8'h10);
    press(1'b0, 1'b1, "lap_out",
          v(S_LAP, 1'b1, 1'b0, 8'h01, 8'h23, 8'h45),
          v(S_RUN, 1'b1, 1'b0, 8'h01, 8'h24, 8'h10),
          v(S_RUN, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00),
          8'h02, 8'h00, 8'h00);

    // pause, clear from pause, clear again from idle
    press(1'b1, 1'b0, "pause",
          v(S_RUN, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00),
          v(S_PAUSE, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00),
          v(S_PAUSE, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00),
          8'h02, 8'h00, 8'h00);
    press(1'b0, 1'b1, "clear",
          v(S_PAUSE, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00),
          v(S_IDLE, 1'b0, 1'b1, 8'h02, 8'h00, 8'h00),
          v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00),
          8'h00, 8'h00, 8'h00);
    press(1'b0, 1'b1, "idle_clr",
          v(S_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00),
          v(S_IDLE, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00),
          v(S_IDLE, 1'b0, 1'b0, 8'h03, 8'h33, 8'h33),
          8'h03, 8'h33, 8'h33);

    // run, then both buttons together: start/stop wins
    press(1'b1, 1'b0, "run2",
          v(S_IDLE, 1'b0, 1'b0, 8'h03, 8'h33, 8'h33),
          v(S_RUN, 1'b1, 1'b0, 8'h03, 8'h33, 8'h33),
          v(S_RUN, 1'b1, 1'b0, 8'h03, 8'h33, 8'h33),
          8'h03, 8'h33, 8'h33);
    press(1'b1, 1'b1, "both",
          v(S_RUN, 1'b1, 1'b0, 8'h03, 8'h33, 8'h33),
          v(S_PAUSE, 1'b0, 1'b0, 8'h03, 8'h33, 8'h33),
          v(S_PAUSE, 1'b0, 1'b0, 8'h03, 8'h34, 8'h00),
          8'h03, 8'h34, 8'h00);

    // re-enter LAP, then reset asynchronously mid-LAP
    press(1'b1, 1'b0, "run3",
          v(S_PAUSE, 1'b0, 1'b0, 8'h03, 8'h34, 8'h00),
          v(S_RUN, 1'b1, 1'b0, 8'h03, 8'h34, 8'h00),
          v(S_RUN, 1'b1, 1'b0, 8'h05, 8'h06, 8'h07),
          8'h05, 8'h06, 8'h07);
    press(1'b0, 1'b1, "lap2",
          v(S_RUN, 1'b1, 1'b0, 8'h05, 8'h06, 8'h07),
          v(S_LAP, 1'b1, 1'b0, 8'h05, 8'h06, 8'h07),
          v(S_LAP, 1'b1, 1'b0, 8'h05, 8'h06, 8'h07),
          8'h05, 8'h07, 8'h00);

    // asserted just after a rising edge; checked before the next one
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(cyc, "rst_mid_lap", v(S_IDLE, 1'b0, 1'b0, 8'h05, 8'h07, 8'h00));
    tick(3);
    rst = 1'b0;
    tick(2);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      errors += exp_q.size();
      checks += exp_q.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
